fix_serializer: RTL and testbench

Transmit-side counterpart of the FIX field parser. It accepts a byte stream of alternating tag and value tokens, inserts the `=` separator after each tag and SOH (0x01) after each value, and on end-of-message appends the FIX checksum trailer `10=NNN<SOH>`. It packs the result into 32-bit words, first byte in lane 0 (`[7:0]`), the same lane order the parser consumes. It sits between the order-building logic and the outbound word stream.

---
 rtl/fix_pkg.sv | 49 ++++
 rtl/fix_byte_packer.sv | 75 +++++++
 rtl/fix_serializer.sv | 193 +++++++++++++++++++
 tb/tb_fix_serializer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fix_pkg
// Description : Shared FIX framing constants, transmit emitter state type and
//               checksum digit conversion helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fix_pkg;

    localparam logic [7:0] SOH_C   = 8'h01;
    localparam logic [7:0] SEP_C   = 8'h3D;
    localparam logic [7:0] ASCII_0 = 8'h30;

    typedef enum logic [3:0] {
        ST_TAG   = 4'd0,
        ST_EQ    = 4'd1,
        ST_VAL   = 4'd2,
        ST_SOH   = 4'd3,
        ST_C1    = 4'd4,
        ST_C0    = 4'd5,
        ST_CEQ   = 4'd6,
        ST_D2    = 4'd7,
        ST_D1    = 4'd8,
        ST_D0    = 4'd9,
        ST_CSOH  = 4'd10,
        ST_FLUSH = 4'd11
    } fix_tx_state_t;

    // Three zero-padded ASCII digits {hundreds, tens, ones} of an 8-bit sum.
    function automatic logic [23:0] cksum_digits(input logic [7:0] sum);
        logic [7:0] hund;
        logic [7:0] rem;
        logic [7:0] tens;
        logic [7:0] ones;
        if (sum >= 8'd200) begin
            hund = 8'd2;
        end else if (sum >= 8'd100) begin
            hund = 8'd1;
        end else begin
            hund = 8'd0;
        end
        rem  = sum - (hund * 8'd100);
        tens = rem / 8'd10;
        ones = rem - (tens * 8'd10);
        return {ASCII_0 + hund, ASCII_0 + tens, ASCII_0 + ones};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fix_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : fix_byte_packer
// Description : Packs a byte stream into 32-bit words, lane 0 first. A word is
//               issued when four lanes are full or the message's last byte
//               arrives; the output register holds under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fix_byte_packer
    import fix_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic        o_ready,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_data,
    output logic [2:0]  o_nbytes,
    output logic        o_last
);

    logic [1:0]  r_cnt;
    logic [31:0] r_acc;
    logic        r_valid;
    logic [31:0] r_data;
    logic [2:0]  r_nbytes;
    logic        r_last;

    logic        w_accept;
    logic        w_load;
    logic [31:0] w_word;

    // A new byte can enter whenever the output register is empty or draining.
    assign o_ready  = !r_valid || i_ready;
    assign w_accept = i_push && o_ready;
    assign w_load   = w_accept && ((r_cnt == 2'd3) || i_last);
    assign w_word   = r_acc | ({24'd0, i_byte} << {r_cnt, 3'b000});

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_nbytes = r_nbytes;
    assign o_last   = r_last;

    // Lane accumulation and output register; a load may coincide with handoff.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= 2'd0;
            r_acc    <= 32'd0;
            r_valid  <= 1'b0;
            r_data   <= 32'd0;
            r_nbytes <= 3'd0;
            r_last   <= 1'b0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_data   <= w_word;
            r_nbytes <= {1'b0, r_cnt} + 3'd1;
            r_last   <= i_last;
            r_cnt    <= 2'd0;
            r_acc    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_acc <= w_word;
                r_cnt <= r_cnt + 2'd1;
            end
            if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fix_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fix_serializer
// Description : FIX transmit framer. Inserts '=' after tags and SOH after
//               values, optionally appends the "10=NNN<SOH>" checksum trailer
//               at end of message, and packs the bytes into 32-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module fix_serializer
    import fix_pkg::*;
#(
    parameter logic CKSUM_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    input  logic        in_eom,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_nbytes,
    output logic        out_last
);

    fix_tx_state_t r_state;
    logic          r_run;
    logic          r_eom;
    logic [7:0]    r_sum;
    logic [23:0]   r_digits;

    logic          w_pk_ready;
    logic          w_pass;
    logic          w_push;
    logic [7:0]    w_byte;
    logic          w_last;
    logic          w_fire;
    logic          w_sum_en;

    // Input bytes flow only in the pass-through states and only after reset.
    assign w_pass   = (r_state == ST_TAG) || (r_state == ST_VAL);
    assign in_ready = r_run && w_pass && w_pk_ready;
    assign w_fire   = w_push && w_pk_ready;
    assign w_sum_en = w_fire && ((r_state == ST_TAG) || (r_state == ST_EQ) ||
                                 (r_state == ST_VAL) || (r_state == ST_SOH));

    // Byte source select: pass-through input or an inserted/trailer byte.
    always_comb begin
        w_push = 1'b0;
        w_byte = 8'h00;
        w_last = 1'b0;
        case (r_state)
            ST_TAG, ST_VAL: begin
                w_push = in_valid && in_ready;
                w_byte = in_byte;
            end
            ST_EQ: begin
                w_push = 1'b1;
                w_byte = SEP_C;
            end
            ST_SOH: begin
                w_push = 1'b1;
                w_byte = SOH_C;
                w_last = r_eom && !CKSUM_EN;
            end
            ST_C1: begin
                w_push = 1'b1;
                w_byte = ASCII_0 + 8'd1;
            end
            ST_C0: begin
                w_push = 1'b1;
                w_byte = ASCII_0;
            end
            ST_CEQ: begin
                w_push = 1'b1;
                w_byte = SEP_C;
            end
            ST_D2: begin
                w_push = 1'b1;
                w_byte = r_digits[23:16];
            end
            ST_D1: begin
                w_push = 1'b1;
                w_byte = r_digits[15:8];
            end
            ST_D0: begin
                w_push = 1'b1;
                w_byte = r_digits[7:0];
            end
            ST_CSOH: begin
                w_push = 1'b1;
                w_byte = SOH_C;
                w_last = 1'b1;
            end
            default: begin
                w_push = 1'b0;
            end
        endcase
    end

    // Emitter FSM with running checksum; every state advances on a fired byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_TAG;
            r_run    <= 1'b0;
            r_eom    <= 1'b0;
            r_sum    <= 8'd0;
            r_digits <= 24'd0;
        end else begin
            r_run <= 1'b1;
            if (w_sum_en) begin
                r_sum <= r_sum + w_byte;
            end
            case (r_state)
                ST_TAG: begin
                    if (w_fire && in_last) r_state <= ST_EQ;
                end
                ST_EQ: begin
                    if (w_fire) r_state <= ST_VAL;
                end
                ST_VAL: begin
                    if (w_fire && in_last) begin
                        r_eom   <= in_eom;
                        r_state <= ST_SOH;
                    end
                end
                ST_SOH: begin
                    if (w_fire) begin
                        if (!r_eom) begin
                            r_state <= ST_TAG;
                        end else if (CKSUM_EN) begin
                            // The SOH being emitted now is the last summed byte.
                            r_digits <= cksum_digits(r_sum + SOH_C);
                            r_state  <= ST_C1;
                        end else begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_C1: begin
                    if (w_fire) r_state <= ST_C0;
                end
                ST_C0: begin
                    if (w_fire) r_state <= ST_CEQ;
                end
                ST_CEQ: begin
                    if (w_fire) r_state <= ST_D2;
                end
                ST_D2: begin
                    if (w_fire) r_state <= ST_D1;
                end
                ST_D1: begin
                    if (w_fire) r_state <= ST_D0;
                end
                ST_D0: begin
                    if (w_fire) r_state <= ST_CSOH;
                end
                ST_CSOH: begin
                    if (w_fire) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    // Hold input off until the message's final word is taken.
                    if (out_valid && out_ready && out_last) begin
                        r_state <= ST_TAG;
                        r_sum   <= 8'd0;
                        r_eom   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_TAG;
                end
            endcase
        end
    end

    fix_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_byte   (w_byte),
        .i_last   (w_last),
        .o_ready  (w_pk_ready),
        .o_valid  (out_valid),
        .i_ready  (out_ready),
        .o_data   (out_data),
        .o_nbytes (out_nbytes),
        .o_last   (out_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_fix_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fix_serializer
// Description : Self-checking bench for fix_serializer. Two instances (with
//               and without checksum trailer); expected words are derived
//               from a byte-level framing model and compared per handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fix_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic [7:0]  in_byte    [2];
    logic        in_last    [2];
    logic        in_eom     [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [31:0] out_data   [2];
    logic [2:0]  out_nbytes [2];
    logic        out_last   [2];

    always #5 clk = ~clk;

    fix_serializer #(.CKSUM_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_byte(in_byte[0]),
        .in_last(in_last[0]), .in_eom(in_eom[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_nbytes(out_nbytes[0]), .out_last(out_last[0])
    );

    fix_serializer #(.CKSUM_EN(1'b0)) dut_nock (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_byte(in_byte[1]),
        .in_last(in_last[1]), .in_eom(in_eom[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_nbytes(out_nbytes[1]), .out_last(out_last[1])
    );

    int checks = 0;
    int errors = 0;

    // Word layout: {last, nbytes[2:0], data[31:0]}
    logic [35:0] exp0[$];
    logic [35:0] exp1[$];
    logic [35:0] got0[$];
    logic [35:0] got1[$];

    logic [7:0] msg_b[$];
    bit         msg_l[$];
    bit         msg_e[$];

    bit          abort_mode = 1'b0;
    bit          rdy_rand  [2];
    bit          force_low [2];
    bit          prev_stall[2];
    logic [35:0] prev_word [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int exp_size(input int d);
        return (d == 0) ? exp0.size() : exp1.size();
    endfunction

    // ---------------- message building ----------------
    function automatic void msg_clear();
        msg_b.delete();
        msg_l.delete();
        msg_e.delete();
    endfunction

    function automatic void add_byte(input logic [7:0] b, input bit last, input bit eom);
        msg_b.push_back(b);
        msg_l.push_back(last);
        msg_e.push_back(eom);
    endfunction

    function automatic void msg_two(input logic [7:0] t, input logic [7:0] v);
        msg_clear();
        add_byte(t, 1'b1, 1'b0);
        add_byte(v, 1'b1, 1'b1);
    endfunction

    function automatic void msg_case1();
        msg_clear();
        add_byte(8'h33, 1'b0, 1'b0);
        add_byte(8'h35, 1'b1, 1'b1);   // eom on a tag: ignored
        add_byte(8'h41, 1'b1, 1'b1);
    endfunction

    // Random message; spurious eom on tags and on non-final value bytes.
    function automatic void gen_random_msg();
        int nf;
        int len;
        bit last;
        bit eom;
        msg_clear();
        nf = $urandom_range(1, 4);
        for (int f = 0; f < nf; f++) begin
            for (int tok = 0; tok < 2; tok++) begin
                len = $urandom_range(1, 5);
                for (int k = 0; k < len; k++) begin
                    last = (k == len - 1);
                    if (tok == 1 && last)
                        eom = (f == nf - 1);
                    else
                        eom = 1'($urandom_range(0, 1));
                    add_byte(8'($urandom_range(0, 255)), last, eom);
                end
            end
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic void build_expected(input int d, input bit cksum);
        logic [7:0]  ob[$];
        bit          is_val;
        int          s;
        int          n;
        logic [31:0] data;
        logic [35:0] w;
        is_val = 1'b0;
        for (int i = 0; i < msg_b.size(); i++) begin
            ob.push_back(msg_b[i]);
            if (msg_l[i]) begin
                if (!is_val) begin
                    ob.push_back(8'h3D);
                end else begin
                    ob.push_back(8'h01);
                    if (msg_e[i] && cksum) begin
                        s = 0;
                        foreach (ob[j]) s += int'(ob[j]);
                        s = s % 256;
                        ob.push_back(8'h31);
                        ob.push_back(8'h30);
                        ob.push_back(8'h3D);
                        ob.push_back(8'(48 + s / 100));
                        ob.push_back(8'(48 + (s / 10) % 10));
                        ob.push_back(8'(48 + s % 10));
                        ob.push_back(8'h01);
                    end
                end
                is_val = !is_val;
            end
        end
        for (int k = 0; k < ob.size(); k += 4) begin
            data = 32'd0;
            n = 0;
            for (int j = 0; j < 4; j++) begin
                if (k + j < ob.size()) begin
                    data[8*j +: 8] = ob[k + j];
                    n++;
                end
            end
            w = {(k + 4 >= ob.size()), 3'(n), data};
            if (d == 0) exp0.push_back(w);
            else        exp1.push_back(w);
        end
    endfunction

    // ---------------- output monitor / compare ----------------
    task automatic mon(input int d);
        logic [35:0] w;
        logic [35:0] e;
        w = {out_last[d], out_nbytes[d], out_data[d]};
        if (rst !== 1'b1) begin
            prev_stall[d] = 1'b0;
            return;
        end
        if (prev_stall[d])
            check($sformatf("hold_stable_%0d", d), w, prev_word[d]);
        if (out_valid[d] && !out_ready[d])
            check($sformatf("blocked_in_ready_%0d", d), in_ready[d], 0);
        if (out_valid[d] && out_ready[d]) begin
            if (d == 0) got0.push_back(w);
            else        got1.push_back(w);
            if (!(abort_mode && d == 0)) begin
                checks++;
                if (exp_size(d) == 0) begin
                    errors++;
                    $display("FAIL unexpected_word_%0d: got %h expected none", d, w);
                end else begin
                    e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                    if (w !== e) begin
                        errors++;
                        $display("FAIL word_%0d: got %h expected %h", d, w, e);
                    end
                end
            end
        end
        prev_stall[d] = out_valid[d] && !out_ready[d];
        prev_word[d]  = w;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // out_ready driver: steady, random or forced low.
    initial begin
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (force_low[d])    out_ready[d] = 1'b0;
                else if (rdy_rand[d]) out_ready[d] = 1'($urandom_range(0, 1));
                else                 out_ready[d] = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_msg(input int d, input bit gaps);
        int wait_cnt;
        bit accepted;
        @(posedge clk);
        #1;
        for (int i = 0; i < msg_b.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid[d] = 1'b1;
            in_byte[d]  = msg_b[i];
            in_last[d]  = msg_l[i];
            in_eom[d]   = msg_e[i];
            accepted = 1'b0;
            wait_cnt = 0;
            while (!accepted) begin
                @(negedge clk);
                if (in_ready[d] === 1'b1) accepted = 1'b1;
                @(posedge clk);
                #1;
                wait_cnt++;
                if (!accepted && wait_cnt > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL in_ready_timeout_%0d: got 0 expected 1", d);
                    in_valid[d] = 1'b0;
                    return;
                end
            end
            in_valid[d] = 1'b0;
            in_last[d]  = 1'b0;
            in_eom[d]   = 1'b0;
        end
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (exp_size(d) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain_left_%0d", d), exp_size(d), 0);
        if (d == 0) exp0.delete();
        else        exp1.delete();
        @(negedge clk);
    endtask

    task automatic check_got(input int d, input string name, input logic [35:0] w[$]);
        int sz;
        sz = (d == 0) ? got0.size() : got1.size();
        check({name, "_count"}, sz, w.size());
        for (int i = 0; i < sz && i < w.size(); i++)
            check($sformatf("%s_w%0d", name, i), (d == 0) ? got0[i] : got1[i], w[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_out_valid_%0d", tag, d), out_valid[d], 0);
            check($sformatf("%s_out_data_%0d", tag, d), out_data[d], 0);
            check($sformatf("%s_out_nbytes_%0d", tag, d), out_nbytes[d], 0);
            check($sformatf("%s_out_last_%0d", tag, d), out_last[d], 0);
            check($sformatf("%s_in_ready_%0d", tag, d), in_ready[d], 0);
        end
    endtask

    logic [35:0] lit[$];

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_byte[d] = 8'h00; in_last[d] = 1'b0; in_eom[d] = 1'b0;
            rdy_rand[d] = 1'b0; force_low[d] = 1'b0; prev_stall[d] = 1'b0; prev_word[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_during_release", in_ready[0], 0);
        @(negedge clk);
        check("in_ready_after_reset", in_ready[0], 1);

        // Tag 35, value A, eom: sum 231.
        msg_case1(); build_expected(0, 1'b1); got0.delete();
        send_msg(0, 1'b0); wait_drain(0);
        lit = '{{1'b0, 3'd4, 32'h413D3533}, {1'b0, 3'd4, 32'h3D303101}, {1'b1, 3'd4, 32'h01313332}};
        check_got(0, "case1", lit);

        // Tag 9, value 5, eom: sum 172.
        msg_two(8'h39, 8'h35); build_expected(0, 1'b1); got0.delete();
        send_msg(0, 1'b0); wait_drain(0);
        lit = '{{1'b0, 3'd4, 32'h01353D39}, {1'b0, 3'd4, 32'h313D3031}, {1'b1, 3'd3, 32'h00013237}};
        check_got(0, "case2", lit);

        // No trailer.
        msg_case1(); build_expected(1, 1'b0); got1.delete();
        send_msg(1, 1'b0); wait_drain(1);
        lit = '{{1'b0, 3'd4, 32'h413D3533}, {1'b1, 3'd1, 32'h00000001}};
        check_got(1, "nock", lit);

        // Five cycles of backpressure mid-message.
        msg_case1(); build_expected(0, 1'b1); got0.delete();
        fork
            send_msg(0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                force_low[0] = 1'b1;
                repeat (5) @(posedge clk);
                force_low[0] = 1'b0;
            end
        join
        wait_drain(0);
        lit = '{{1'b0, 3'd4, 32'h413D3533}, {1'b0, 3'd4, 32'h3D303101}, {1'b1, 3'd4, 32'h01313332}};
        check_got(0, "bp", lit);

        // Sum 7 and sum 0 (wrap).
        msg_two(8'h64, 8'h65); build_expected(0, 1'b1); got0.delete();
        send_msg(0, 1'b0); wait_drain(0);
        check("sum7_last", (got0.size() > 0) ? got0[got0.size()-1] : 36'd0, {1'b1, 3'd3, 32'h00013730});
        msg_two(8'h64, 8'h5E); build_expected(0, 1'b1); got0.delete();
        send_msg(0, 1'b0); wait_drain(0);
        check("sum0_last", (got0.size() > 0) ? got0[got0.size()-1] : 36'd0, {1'b1, 3'd3, 32'h00013030});

        // Reset after six bytes, then the first case again.
        abort_mode = 1'b1;
        msg_clear();
        add_byte(8'h33, 1'b0, 1'b0); add_byte(8'h35, 1'b1, 1'b0);
        add_byte(8'h41, 1'b0, 1'b0); add_byte(8'h42, 1'b0, 1'b0);
        add_byte(8'h43, 1'b0, 1'b0); add_byte(8'h44, 1'b0, 1'b0);
        send_msg(0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        abort_mode = 1'b0;
        got0.delete(); exp0.delete();
        msg_case1(); build_expected(0, 1'b1);
        send_msg(0, 1'b0); wait_drain(0);
        repeat (10) @(negedge clk);
        lit = '{{1'b0, 3'd4, 32'h413D3533}, {1'b0, 3'd4, 32'h3D303101}, {1'b1, 3'd4, 32'h01313332}};
        check_got(0, "after_abort", lit);

        // Randomized messages against the model on both instances.
        for (int n = 0; n < 40; n++) begin
            int d;
            d = n % 2;
            rdy_rand[d] = 1'($urandom_range(0, 1));
            gen_random_msg();
            build_expected(d, d == 0);
            send_msg(d, 1'b1);
            wait_drain(d);
        end
        rdy_rand[0] = 1'b0;
        rdy_rand[1] = 1'b0;
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
